// File: rtl/ps2_enc_pkg.sv
// Shared types and constants for the ps2_key event encoder: event record,
// default key-index to scan-code map, ps2_key bit positions and emitter states.
package ps2_enc_pkg;

    typedef struct packed {
        logic       pressed;
        logic [8:0] code;
    } ps2_evt_t;

    localparam int PS2_TOGGLE_BIT  = 10;
    localparam int PS2_PRESSED_BIT = 9;
    localparam int PS2_EXT_BIT     = 8;
    localparam int PS2_CODE_MSB    = 8;

    // Bit 8 set marks an E0-prefixed (extended) code
    localparam logic [8:0] KEY_CODE [16] = '{
        9'h175, 9'h172, 9'h16B, 9'h174,
        9'h029, 9'h014, 9'h016, 9'h01E,
        9'h02E, 9'h036, 9'h02D, 9'h02B,
        9'h023, 9'h034, 9'h01C, 9'h005
    };

    typedef enum logic [0:0] {
        EMIT_IDLE = 1'b0,
        EMIT_HOLD = 1'b1
    } emit_state_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO of ps2_evt_t. Pointers carry one extra bit so a full
// buffer is distinguishable from an empty one; the head entry is always visible on dout.
module ps2_evt_fifo
    import ps2_enc_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        push,
    input  ps2_evt_t    din,
    input  logic        pop,
    output ps2_evt_t    dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    ps2_evt_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage holds data only; validity is defined entirely by the pointers
    always_ff @(posedge clk_sys) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_key_encoder.sv
// Scans level key states and emits one ps2_key toggle event per change, paced by GAP.
// Optional AUTOREPEAT_EN build adds typematic repeat of the most recently pressed key.
module ps2_key_encoder
    import ps2_enc_pkg::*;
#(
    parameter int          NKEYS        = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          GAP          = 4,
    parameter logic [23:0] REPEAT_DELAY = 24'd6000000,
    parameter logic [23:0] REPEAT_PER   = 24'd1200000
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic [NKEYS-1:0]              keys,
    output logic [10:0]                   ps2_key,
    output logic                          pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl
);

    localparam int PW = $clog2(NKEYS);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [NKEYS-1:0]   reported;
    logic [NKEYS-1:0]   diff;
    logic [2*NKEYS-1:0] diff_dbl;
    logic [NKEYS-1:0]   diff_rot;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      sel_off;
    logic [PW:0]        sel_sum;
    logic [PW-1:0]      sel_idx;
    logic               sel_vld;
    logic               scan_push;
    ps2_evt_t           scan_evt;

    logic               fifo_push;
    ps2_evt_t           push_evt;
    ps2_evt_t           fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    emit_state_t        state, state_nxt;
    logic [GW-1:0]      gap_cnt, gap_nxt;
    logic [10:0]        key_nxt;

    // Change detect: rotate diff so offset 0 is the scan pointer, take the lowest set bit
    assign diff     = keys ^ reported;
    assign diff_dbl = {diff, diff} >> ptr;
    assign diff_rot = diff_dbl[NKEYS-1:0];

    always_comb begin
        sel_vld = 1'b0;
        sel_off = '0;
        for (int k = NKEYS-1; k >= 0; k--) begin
            if (diff_rot[k]) begin
                sel_vld = 1'b1;
                sel_off = PW'(k);
            end
        end
    end

    assign sel_sum   = {1'b0, ptr} + {1'b0, sel_off};
    assign sel_idx   = (sel_sum >= (PW+1)'(NKEYS)) ? PW'(sel_sum - (PW+1)'(NKEYS)) : PW'(sel_sum);
    assign scan_push = sel_vld && !fifo_full;
    assign scan_evt  = '{pressed: keys[sel_idx], code: KEY_CODE[sel_idx]};

    // A blocked change leaves reported[] alone so it stays visible in diff
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            reported <= '0;
            ptr      <= '0;
        end else if (scan_push) begin
            reported[sel_idx] <= keys[sel_idx];
            ptr               <= (sel_idx == PW'(NKEYS-1)) ? '0 : sel_idx + 1'b1;
        end
    end

`ifdef AUTOREPEAT_EN
    logic          rep_act;
    logic [PW-1:0] rep_idx;
    logic [23:0]   rep_cnt;
    logic          rep_due;
    logic          rep_push;

    assign rep_due  = rep_act && keys[rep_idx] && (rep_cnt == '0) && !scan_push;
    assign rep_push = rep_due && !fifo_full;

    // Any scan push re-arms on that key; a dropped repeat still restarts the period
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rep_act <= 1'b0;
            rep_idx <= '0;
            rep_cnt <= '0;
        end else if (scan_push) begin
            rep_act <= keys[sel_idx];
            rep_idx <= sel_idx;
            rep_cnt <= REPEAT_DELAY - 24'd1;
        end else if (rep_act && !keys[rep_idx]) begin
            rep_act <= 1'b0;
        end else if (rep_due) begin
            rep_cnt <= REPEAT_PER - 24'd1;
        end else if (rep_act) begin
            rep_cnt <= rep_cnt - 24'd1;
        end
    end

    assign fifo_push = scan_push | rep_push;
    assign push_evt  = scan_push ? scan_evt : '{pressed: 1'b1, code: KEY_CODE[rep_idx]};
`else
    assign fifo_push = scan_push;
    assign push_evt  = scan_evt;
`endif

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (fifo_push),
        .din     (push_evt),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_lvl)
    );

    // Emitter: pop and toggle, then hold off so toggles are at least GAP cycles apart
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        key_nxt   = ps2_key;
        pop       = 1'b0;
        case (state)
            EMIT_IDLE: begin
                if (!fifo_empty && gap_cnt == '0) begin
                    pop       = 1'b1;
                    key_nxt   = {~ps2_key[PS2_TOGGLE_BIT], fifo_dout};
                    gap_nxt   = GW'(GAP - 1);
                    state_nxt = (GAP > 1) ? EMIT_HOLD : EMIT_IDLE;
                end
            end
            EMIT_HOLD: begin
                gap_nxt = gap_cnt - 1'b1;
                if (gap_cnt == GW'(1))
                    state_nxt = EMIT_IDLE;
            end
            default: state_nxt = EMIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= EMIT_IDLE;
            gap_cnt <= '0;
            ps2_key <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            ps2_key <= key_nxt;
        end
    end

    assign pending = (fifo_lvl != '0) | (|diff);

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: directed scenarios plus random key activity, every
// cycle compared with a queue-based event model. Repeat checks follow AUTOREPEAT_EN.
module tb_ps2_key_encoder;

    localparam int NK = 16;
    localparam int DEPTH = 8;
    localparam int GAPC = 4;
    localparam int RD = 20;
    localparam int RP = 10;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] keys;
    logic [10:0] ps2_key;
    logic        pending;
    logic [3:0]  fifo_lvl;

    int n_vec  = 0;
    int n_miss = 0;

    logic [8:0] codes [16] = '{
        9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h014, 9'h016, 9'h01E,
        9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h005
    };

    // Reference model state
    logic [9:0]  mq [$];
    logic [15:0] m_rep;
    int          m_ptr;
    int          m_since;
    logic        m_tog;
    logic [9:0]  m_data;
    int          m_cyc;
    logic        m_ract;
    int          m_ridx;
    int          m_rdue;

    ps2_key_encoder #(
        .NKEYS        (NK),
        .FIFO_DEPTH   (DEPTH),
        .GAP          (GAPC),
        .REPEAT_DELAY (24'(RD)),
        .REPEAT_PER   (24'(RP))
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .keys     (keys),
        .ps2_key  (ps2_key),
        .pending  (pending),
        .fifo_lvl (fifo_lvl)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rep   = '0;
        m_ptr   = 0;
        m_since = GAPC;
        m_tog   = 1'b0;
        m_data  = '0;
        m_ract  = 1'b0;
        m_ridx  = 0;
        m_rdue  = 0;
    endtask

    // Advance the model across one rising edge using the keys currently driven
    task automatic model_step();
        logic       do_pop, found, push, scan_push;
        logic [9:0] evt;
        int         old_sz, idx, cand;
        logic [15:0] d;
        m_cyc++;
        old_sz = mq.size();
        do_pop = (old_sz > 0) && (m_since >= GAPC);
        d      = keys ^ m_rep;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NK; k++) begin
            cand = (m_ptr + k) % NK;
            if (!found && d[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        scan_push = found && (old_sz < DEPTH);
        push = 1'b0;
        evt  = '0;
        if (scan_push) begin
            evt        = {keys[idx], codes[idx]};
            m_rep[idx] = keys[idx];
            m_ptr      = (idx + 1) % NK;
            push       = 1'b1;
        end
`ifdef AUTOREPEAT_EN
        if (scan_push) begin
            m_ract = keys[idx];
            m_ridx = idx;
            m_rdue = m_cyc + RD;
        end else if (m_ract && !keys[m_ridx]) begin
            m_ract = 1'b0;
        end else if (m_ract && m_cyc == m_rdue) begin
            if (old_sz < DEPTH) begin
                push = 1'b1;
                evt  = {1'b1, codes[m_ridx]};
            end
            m_rdue = m_cyc + RP;
        end
`endif
        if (do_pop) begin
            m_data  = mq.pop_front();
            m_tog   = ~m_tog;
            m_since = 1;
        end else begin
            m_since++;
        end
        if (push)
            mq.push_back(evt);
    endtask

    task automatic check_all();
        chk("ps2_key", 32'(ps2_key), 32'({m_tog, m_data}));
        chk("pending", 32'(pending), 32'((mq.size() != 0) || ((keys ^ m_rep) != 0)));
        chk("fifo_lvl", 32'(fifo_lvl), 32'(mq.size()));
    endtask

    task automatic tick();
        @(negedge clk_sys);
        check_all();
    endtask

    task automatic drive(input logic [15:0] k);
        keys = k;
        model_step();
    endtask

    task automatic step_keys(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive(k);
        end
    endtask

    initial begin
        logic [15:0] kv;
        m_cyc = 0;
        keys  = '0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_sys);
        chk("rst_ps2_key", 32'(ps2_key), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_fifo_lvl", 32'(fifo_lvl), 32'h0);
        reset = 1'b0;

        // Single press: event two edges after the change
        drive(16'h0001);
        step_keys(16'h0001, 1);
        tick();
        chk("t1_first_evt", 32'(ps2_key), 32'h775);
        chk("t1_pending", 32'(pending), 32'h0);
        drive(16'h0001);
        step_keys(16'h0001, 10);

        // Space press, hold, release
        step_keys(16'h0011, 10);
        step_keys(16'h0001, 10);
        chk("t2_release_evt", 32'(ps2_key[9:0]), 32'h029);
        step_keys(16'h0000, 10);

        // All keys at once: FIFO fills and drains in index order
        step_keys(16'hFFFF, 80);
        step_keys(16'h0000, 80);

        // Blocked pulse on key 9, then held press
        step_keys(16'hFDFF, 1);
        for (int i = 0; i < 30 && mq.size() < DEPTH; i++)
            step_keys(16'hFDFF, 1);
        chk("t4_full", 32'(mq.size()), 32'(DEPTH));
        step_keys(16'hFFFF, 1);
        step_keys(16'hFDFF, 1);
        step_keys(16'hFDFF, 60);
        step_keys(16'hFFFF, 30);
        chk("t4_held_evt", 32'(ps2_key[9:0]), 32'h236);
        step_keys(16'h0000, 80);

        // Reset shortly after a push
        step_keys(16'h0008, 1);
        tick();
        #1 reset = 1'b1;
        model_reset();
        keys = '0;
        #1;
        chk("t5_ps2_key", 32'(ps2_key), 32'h0);
        chk("t5_fifo_lvl", 32'(fifo_lvl), 32'h0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        drive(16'h0000);
        step_keys(16'h0000, 10);

        // Held key (repeats only in the AUTOREPEAT_EN build), then release
        step_keys(16'h0002, 70);
        step_keys(16'h0000, 40);

        // Random key activity
        kv = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0)
                kv[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0)
                kv = 16'($urandom);
            step_keys(kv, 1);
        end
        step_keys(16'h0000, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
